hd_bitmask_pipe: RTL and testbench



---
 rtl/hd_bitmask_pipe.sv | 155 +++++++++++++++
 tb/tb_hd_bitmask_pipe.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_bitmask_pipe.sv
// hd_bitmask_pipe: streaming rightmost-bit mask operations
// with registered result, nonzero flag and popcount.
module hd_bitmask_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int CW     = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [2:0]    in_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_nz,
    output logic [CW-1:0] out_cnt,
    output logic [15:0]   out_beats
);

    localparam int L = STAGES - 1;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] ld;
    logic [W-1:0]      d_q    [STAGES];
    logic [W-1:0]      load_d [STAGES];
    logic              nz_q;
    logic [CW-1:0]     cnt_q;
    logic [15:0]       beats_q;

    function automatic logic [W-1:0] mask_op(
        input logic [W-1:0] x,
        input logic [2:0]   m
    );
        logic [W-1:0] one;
        logic [W-1:0] dec;
        logic [W-1:0] inc;
        logic [W-1:0] r;
        one = W'(1);
        dec = x - one;
        inc = x + one;
        r   = '0;
        unique case (m)
            3'd0: r = x & dec;
            3'd1: r = x | inc;
            3'd2: r = x & (~x + one);
            3'd3: r = ~x & dec;
            3'd4: r = ~x & inc;
            3'd5: r = x ^ dec;
            3'd6: r = x | dec;
            3'd7: r = ((x | dec) + one) & x;
        endcase
        return r;
    endfunction

    function automatic logic [CW-1:0] pop(input logic [W-1:0] x);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + CW'(x[i]);
        end
        return c;
    endfunction

    // Load enables: a slot loads if it or any slot after it has room,
    // or the output drains.
    always_comb begin
        logic acc;
        ld  = '0;
        acc = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc   = acc | ~v_q[k];
            ld[k] = acc;
        end
    end

    // Valid bit offered to each slot by its upstream neighbour.
    always_comb begin
        up_v    = '0;
        up_v[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v_q[k-1];
        end
    end

    // Operation is evaluated on entry to slot 1 (or slot 0 when
    // there is only one slot); later slots just carry the result.
    if (STAGES == 1) begin : g_eval
        assign load_d[0] = mask_op(in_data, in_mode);
    end else begin : g_eval
        logic [2:0] m0_q;

        // Mode travels with the raw operand in slot 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                m0_q <= '0;
            end else if (ld[0]) begin
                m0_q <= in_mode;
            end
        end

        assign load_d[0] = in_data;
        assign load_d[1] = mask_op(d_q[0], m0_q);
        for (genvar k = 2; k < STAGES; k++) begin : g_pass
            assign load_d[k] = d_q[k-1];
        end
    end

    // Slot registers advance independently so bubbles collapse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    v_q[k] <= up_v[k];
                    d_q[k] <= load_d[k];
                end
            end
        end
    end

    // Flag and popcount register alongside the last slot's data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nz_q  <= 1'b0;
            cnt_q <= '0;
        end else if (ld[L]) begin
            nz_q  <= |load_d[L];
            cnt_q <= pop(load_d[L]);
        end
    end

    // Delivered-beat counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats_q <= '0;
        end else if (v_q[L] & out_ready) begin
            beats_q <= beats_q + 16'd1;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[L];
    assign out_data  = d_q[L];
    assign out_nz    = nz_q;
    assign out_cnt   = cnt_q;
    assign out_beats = beats_q;

endmodule

// File: tb/tb_hd_bitmask_pipe.sv
// tb_hd_bitmask_pipe: directed vectors on an 8/2 instance plus
// random streams on 1/1, 8/2 and 64/4 against a trailing-bit model.
module tb_hd_bitmask_pipe;

    localparam int NRAND = 10000;
    localparam int LIMIT = 60000;

    typedef struct {
        logic [7:0] x;
        logic [2:0] m;
        logic [7:0] d;
        logic       nz;
        logic [3:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_nz;
    logic [3:0] out_cnt;
    logic [15:0] out_beats;

    int   n_chk = 0;
    int   n_err = 0;
    bit   rand_go = 1'b0;
    bit [2:0] rand_done = '0;
    vec_t tbl [13];

    always #5 clk = ~clk;

    hd_bitmask_pipe #(.W(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nz    (out_nz),
        .out_cnt   (out_cnt),
        .out_beats (out_beats)
    );

    task automatic chk(input string nm, input longint unsigned act,
                       input longint unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: described via lowest set bit / lowest clear bit.
    function automatic longint unsigned ref_op(input longint unsigned xi,
                                               input int m, input int w);
        longint unsigned all;
        longint unsigned x;
        longint unsigned r;
        int tz;
        int to;
        all = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 1);
        x = xi & all;
        tz = w;
        to = w;
        for (int i = w - 1; i >= 0; i--) begin
            if (x[i])  tz = i;
            if (!x[i]) to = i;
        end
        case (m)
            0: r = (tz < w) ? (x & ~(64'd1 << tz)) : 64'd0;
            1: r = (to < w) ? (x | (64'd1 << to)) : x;
            2: r = (tz < w) ? (64'd1 << tz) : 64'd0;
            3: r = (tz < w) ? ((64'd1 << tz) - 1) : all;
            4: r = (to < w) ? (64'd1 << to) : 64'd0;
            5: r = (tz < w) ? ((64'd1 << (tz + 1)) - 1) : all;
            6: r = (tz < w) ? (x | ((64'd1 << tz) - 1)) : all;
            default: begin
                r = x;
                for (int i = tz; i < w; i++) begin
                    if (!r[i]) break;
                    r[i] = 1'b0;
                end
            end
        endcase
        return r & all;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        v = tbl[idx];
        in_valid  = 1'b1;
        in_data   = v.x;
        in_mode   = v.m;
        out_ready = 1'b1;
        @(negedge clk);
        chk($sformatf("tbl%0d_in_ready", idx), in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk($sformatf("tbl%0d_early", idx), out_valid, 0);
        @(posedge clk);
        #1;
        chk($sformatf("tbl%0d_valid", idx), out_valid, 1);
        chk($sformatf("tbl%0d_data", idx), out_data, v.d);
        chk($sformatf("tbl%0d_nz", idx), out_nz, v.nz);
        chk($sformatf("tbl%0d_cnt", idx), out_cnt, v.cnt);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int WG = (g == 0) ? 1 : (g == 1) ? 8 : 64;
        localparam int SG = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        localparam int CG = $clog2(WG + 1);

        logic          iv;
        logic          ir;
        logic [WG-1:0] id;
        logic [2:0]    im;
        logic          ov;
        logic          orr;
        logic [WG-1:0] od;
        logic          onz;
        logic [CG-1:0] oc;
        logic [15:0]   ob;

        hd_bitmask_pipe #(.W(WG), .STAGES(SG)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv),
            .in_ready  (ir),
            .in_data   (id),
            .in_mode   (im),
            .out_valid (ov),
            .out_ready (orr),
            .out_data  (od),
            .out_nz    (onz),
            .out_cnt   (oc),
            .out_beats (ob)
        );

        initial begin
            longint unsigned q[$];
            longint unsigned e;
            logic [63:0] r;
            int sent;
            int got;
            int cyc;
            iv  = 1'b0;
            orr = 1'b0;
            id  = '0;
            im  = '0;
            sent = 0;
            got  = 0;
            cyc  = 0;
            wait (rand_go);
            @(posedge clk);
            #1;
            while ((sent < NRAND || q.size() != 0) && cyc < LIMIT) begin
                iv  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
                r   = {$urandom, $urandom};
                id  = r[WG-1:0];
                im  = 3'($urandom_range(0, 7));
                orr = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (ov && orr) begin
                    if (q.size() == 0) begin
                        chk($sformatf("rand%0d_extra", g), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("rand%0d_data", g), od, e);
                        chk($sformatf("rand%0d_nz", g), onz, e != 0);
                        chk($sformatf("rand%0d_cnt", g), oc, $countones(e));
                        chk($sformatf("rand%0d_beats", g), ob, got & 16'hFFFF);
                        got++;
                    end
                end
                if (iv && ir) begin
                    q.push_back(ref_op(64'(id), int'(im), WG));
                    sent++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
            iv  = 1'b0;
            chk($sformatf("rand%0d_timeout", g), cyc < LIMIT, 1);
            chk($sformatf("rand%0d_count", g), got, NRAND);
            chk($sformatf("rand%0d_beats_end", g), ob, got & 16'hFFFF);
            rand_done[g] = 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bp_exp [5];
        int nxt;
        int acc;
        int got;

        tbl[0]  = '{8'h58, 3'd3, 8'h07, 1'b1, 4'd3};
        tbl[1]  = '{8'h00, 3'd3, 8'hFF, 1'b1, 4'd8};
        tbl[2]  = '{8'h5C, 3'd0, 8'h58, 1'b1, 4'd3};
        tbl[3]  = '{8'h5C, 3'd1, 8'h5D, 1'b1, 4'd5};
        tbl[4]  = '{8'h5C, 3'd2, 8'h04, 1'b1, 4'd1};
        tbl[5]  = '{8'h5C, 3'd3, 8'h03, 1'b1, 4'd2};
        tbl[6]  = '{8'h5C, 3'd4, 8'h01, 1'b1, 4'd1};
        tbl[7]  = '{8'h5C, 3'd5, 8'h07, 1'b1, 4'd3};
        tbl[8]  = '{8'h5C, 3'd6, 8'h5F, 1'b1, 4'd6};
        tbl[9]  = '{8'h5C, 3'd7, 8'h40, 1'b1, 4'd1};
        tbl[10] = '{8'h00, 3'd2, 8'h00, 1'b0, 4'd0};
        tbl[11] = '{8'hFF, 3'd1, 8'hFF, 1'b1, 4'd8};
        tbl[12] = '{8'h80, 3'd0, 8'h00, 1'b0, 4'd0};
        bp_exp  = '{8'h01, 8'h03, 8'h03, 8'h07, 8'h05};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_nz", out_nz, 0);
        chk("rst_cnt", out_cnt, 0);
        chk("rst_beats", out_beats, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 13; i++) begin
            run_vec(i);
        end
        @(posedge clk);
        #1;
        chk("tbl_beats", out_beats, 13);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        nxt = 1;
        acc = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            in_valid  = (nxt <= 5);
            in_data   = 8'(nxt);
            in_mode   = 3'd6;
            out_ready = (c >= 6);
            @(negedge clk);
            if (c == 5) begin
                chk("bp_accepted", acc, 2);
                chk("bp_in_ready", in_ready, 0);
                chk("bp_valid", out_valid, 1);
                chk("bp_hold", out_data, 8'h01);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_data%0d", got), out_data, bp_exp[got]);
                got++;
            end
            if (in_valid && in_ready) begin
                nxt++;
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_count", got, 5);
        chk("bp_beats", out_beats, 5);

        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 3'd0;
        in_data   = 8'h11;
        @(posedge clk);
        #1;
        in_data = 8'h22;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("flight_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_beats", out_beats, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("no_stale%0d", c), out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_vec(0);
        @(posedge clk);
        #1;
        chk("post_rst_beats", out_beats, 1);

        rand_go = 1'b1;
        wait (rand_done == 3'b111);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
